// File: rtl/collision_pkg.sv
// Shared types and constants for the multi-pipe collision scanner.
package collision_pkg;

  // Extra bits added to coordinates so edge-of-screen arithmetic stays signed and unwrapped.
  localparam int WIDEN = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BOUND = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    HC_NONE  = 2'd0,
    HC_PIPE  = 2'd1,
    HC_FLOOR = 2'd2,
    HC_CEIL  = 2'd3
  } hit_cause_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipe_overlap.sv
// Combinational single-pipe overlap test on captured coordinates.
module pipe_overlap
  import collision_pkg::*;
#(
  parameter int COORD_W     = 10,
  parameter int BIRD_X      = 320,
  parameter int X_REACH     = 55,
  parameter int BIRD_HALF_H = 12,
  parameter int GAP_HALF    = 40
) (
  input  logic [COORD_W-1:0] bird_y,
  input  logic [COORD_W-1:0] pipe_x,
  input  logic [COORD_W-1:0] pipe_y,
  input  logic               valid,
  output logic               hit
);

  localparam int SW = COORD_W + WIDEN;
  localparam logic signed [SW-1:0] BX = SW'(BIRD_X);
  localparam logic signed [SW-1:0] XR = SW'(X_REACH);
  localparam logic signed [SW-1:0] BH = SW'(BIRD_HALF_H);
  localparam logic signed [SW-1:0] GH = SW'(GAP_HALF);

  logic signed [SW-1:0] by_s;
  logic signed [SW-1:0] px_s;
  logic signed [SW-1:0] py_s;
  logic signed [SW-1:0] dx;
  logic                 x_overlap;
  logic                 y_outside;

  always_comb begin
    by_s      = $signed({{WIDEN{1'b0}}, bird_y});
    px_s      = $signed({{WIDEN{1'b0}}, pipe_x});
    py_s      = $signed({{WIDEN{1'b0}}, pipe_y});
    dx        = px_s - BX;
    x_overlap = (dx <= XR) && (dx >= -XR);
    // Bird touches either lip of the gap.
    y_outside = ((by_s + BH) >= (py_s + GH)) || ((by_s - BH) <= (py_s - GH));
    hit       = valid && x_overlap && y_outside;
  end

endmodule

// File: rtl/collision_scan.sv
// Per-frame collision scanner: captures bird and pipes, tests one pipe per clock, reports a registered verdict.
module collision_scan
  import collision_pkg::*;
#(
  parameter int NUM_PIPES   = 4,
  parameter int COORD_W     = 10,
  parameter int BIRD_X      = 320,
  parameter int X_REACH     = 55,
  parameter int BIRD_HALF_H = 12,
  parameter int GAP_HALF    = 40,
  parameter int FLOOR_Y     = 470,
  parameter int CEIL_Y      = 10,
  parameter int STICKY      = 1,
  localparam int IDX_W      = idx_width(NUM_PIPES)
) (
  input  logic                           Clk,
  input  logic                           Reset_n,
  input  logic                           frame_start,
  input  logic                           clear_hit,
  input  logic [COORD_W-1:0]             bird_y,
  input  logic [NUM_PIPES*COORD_W-1:0]   pipe_x,
  input  logic [NUM_PIPES*COORD_W-1:0]   pipe_y,
  input  logic [NUM_PIPES-1:0]           pipe_valid,
  output logic                           busy,
  output logic                           done,
  output logic                           hit,
  output logic [1:0]                     hit_cause,
  output logic [IDX_W-1:0]               hit_pipe,
  output logic                           overrun
);

  localparam int SW = COORD_W + WIDEN;
  localparam logic signed [SW-1:0] FLOOR_S = SW'(FLOOR_Y);
  localparam logic signed [SW-1:0] CEIL_S  = SW'(CEIL_Y);
  localparam logic [IDX_W-1:0]     LAST    = IDX_W'(NUM_PIPES - 1);

  state_t                       state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [COORD_W-1:0]           bird_y_q, bird_y_d;
  logic [NUM_PIPES*COORD_W-1:0] pipe_x_q, pipe_x_d;
  logic [NUM_PIPES*COORD_W-1:0] pipe_y_q, pipe_y_d;
  logic [NUM_PIPES-1:0]         valid_q, valid_d;
  logic                         floor_q, floor_d;
  logic                         ceil_q, ceil_d;
  logic                         scan_hit_q, scan_hit_d;
  logic [IDX_W-1:0]             scan_idx_q, scan_idx_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic                         hit_q, hit_d;
  hit_cause_t                   cause_q, cause_d;
  logic [IDX_W-1:0]             hit_pipe_q, hit_pipe_d;
  logic                         overrun_q, overrun_d;

  logic [COORD_W-1:0]   mux_x;
  logic [COORD_W-1:0]   mux_y;
  logic                 mux_valid;
  logic                 pipe_hit;
  logic signed [SW-1:0] by_s;
  hit_cause_t           final_cause;

  assign mux_x     = pipe_x_q[idx_q*COORD_W +: COORD_W];
  assign mux_y     = pipe_y_q[idx_q*COORD_W +: COORD_W];
  assign mux_valid = valid_q[idx_q];
  assign by_s      = $signed({{WIDEN{1'b0}}, bird_y_q});

  pipe_overlap #(
    .COORD_W    (COORD_W),
    .BIRD_X     (BIRD_X),
    .X_REACH    (X_REACH),
    .BIRD_HALF_H(BIRD_HALF_H),
    .GAP_HALF   (GAP_HALF)
  ) u_overlap (
    .bird_y(bird_y_q),
    .pipe_x(mux_x),
    .pipe_y(mux_y),
    .valid (mux_valid),
    .hit   (pipe_hit)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    bird_y_d    = bird_y_q;
    pipe_x_d    = pipe_x_q;
    pipe_y_d    = pipe_y_q;
    valid_d     = valid_q;
    floor_d     = floor_q;
    ceil_d      = ceil_q;
    scan_hit_d  = scan_hit_q;
    scan_idx_d  = scan_idx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    hit_d       = hit_q;
    cause_d     = cause_q;
    hit_pipe_d  = hit_pipe_q;
    overrun_d   = frame_start && (state_q != ST_IDLE);
    final_cause = HC_NONE;

    // A result update later in this block takes precedence over the clear.
    if (clear_hit) begin
      hit_d      = 1'b0;
      cause_d    = HC_NONE;
      hit_pipe_d = '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          bird_y_d = bird_y;
          pipe_x_d = pipe_x;
          pipe_y_d = pipe_y;
          valid_d  = pipe_valid;
          idx_d    = '0;
          busy_d   = 1'b1;
          state_d  = ST_BOUND;
        end
      end
      ST_BOUND: begin
        floor_d    = (by_s >= FLOOR_S);
        ceil_d     = (by_s <= CEIL_S);
        scan_hit_d = 1'b0;
        scan_idx_d = '0;
        idx_d      = '0;
        state_d    = ST_SCAN;
      end
      ST_SCAN: begin
        if (pipe_hit && !scan_hit_q) begin
          scan_hit_d = 1'b1;
          scan_idx_d = idx_q;
        end
        if (idx_q == LAST) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          if (floor_q)         final_cause = HC_FLOOR;
          else if (ceil_q)     final_cause = HC_CEIL;
          else if (scan_hit_d) final_cause = HC_PIPE;
          if ((STICKY == 0) || (final_cause != HC_NONE)) begin
            hit_d      = (final_cause != HC_NONE);
            cause_d    = final_cause;
            hit_pipe_d = (final_cause == HC_PIPE) ? scan_idx_d : '0;
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      bird_y_q   <= '0;
      pipe_x_q   <= '0;
      pipe_y_q   <= '0;
      valid_q    <= '0;
      floor_q    <= 1'b0;
      ceil_q     <= 1'b0;
      scan_hit_q <= 1'b0;
      scan_idx_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hit_q      <= 1'b0;
      cause_q    <= HC_NONE;
      hit_pipe_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      bird_y_q   <= bird_y_d;
      pipe_x_q   <= pipe_x_d;
      pipe_y_q   <= pipe_y_d;
      valid_q    <= valid_d;
      floor_q    <= floor_d;
      ceil_q     <= ceil_d;
      scan_hit_q <= scan_hit_d;
      scan_idx_q <= scan_idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      hit_q      <= hit_d;
      cause_q    <= cause_d;
      hit_pipe_q <= hit_pipe_d;
      overrun_q  <= overrun_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign hit       = hit_q;
  assign hit_cause = cause_q;
  assign hit_pipe  = hit_pipe_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_collision_scan.sv
// Directed bench for collision_scan: scoreboard of expected verdicts popped on each done pulse.
module tb_collision_scan;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        clear_hit = 1'b0;
  logic [9:0]  bird_y = '0;
  logic [39:0] pipe_x = '0;
  logic [39:0] pipe_y = '0;
  logic [3:0]  pipe_valid = '0;
  logic        busy, done, hit, overrun;
  logic [1:0]  hit_cause;
  logic [1:0]  hit_pipe;

  typedef struct {
    logic       hit;
    logic [1:0] cause;
    logic [1:0] pipe;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  collision_scan dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_start(frame_start),
    .clear_hit  (clear_hit),
    .bird_y     (bird_y),
    .pipe_x     (pipe_x),
    .pipe_y     (pipe_y),
    .pipe_valid (pipe_valid),
    .busy       (busy),
    .done       (done),
    .hit        (hit),
    .hit_cause  (hit_cause),
    .hit_pipe   (hit_pipe),
    .overrun    (overrun)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_pipes();
    pipe_x = '0;
    pipe_y = '0;
    pipe_valid = '0;
  endtask

  task automatic set_pipe(input int i, input int x, input int y);
    logic [9:0] xv;
    logic [9:0] yv;
    xv = x[9:0];
    yv = y[9:0];
    pipe_x[i*10 +: 10] = xv;
    pipe_y[i*10 +: 10] = yv;
    pipe_valid[i] = 1'b1;
  endtask

  task automatic check_result_zero(input string tag);
    check({tag, ".hit"}, hit, 0);
    check({tag, ".cause"}, hit_cause, 0);
    check({tag, ".pipe"}, hit_pipe, 0);
  endtask

  // Cycle 0 carries frame_start; optional second frame_start, clear_hit and reset at given cycles.
  task automatic run_frame(input string tag, input int by, input int eh, input int ec, input int ep,
                           input int fs2_at, input int clr_at, input int rst_at);
    exp_t e;
    bit   seen;
    logic [9:0] byv;
    byv = by[9:0];
    bird_y = byv;
    e.hit = eh[0];
    e.cause = ec[1:0];
    e.pipe = ep[1:0];
    if (rst_at == 0) sb.push_back(e);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      frame_start = (c == 0) || (fs2_at != 0 && c == fs2_at);
      clear_hit   = (clr_at != 0 && c == clr_at);
      Reset_n     = !(rst_at != 0 && c == rst_at);
      if (fs2_at != 0 && c == fs2_at) bird_y = 10'd470;
      tick();
      frame_start = 1'b0;
      clear_hit   = 1'b0;
      Reset_n     = 1'b1;
      check({tag, ".busy"}, busy, (c + 1 <= 6) && (rst_at == 0 || c + 1 <= rst_at));
      check({tag, ".overrun"}, overrun, (fs2_at != 0 && c == fs2_at));
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          check({tag, ".unexpected_done"}, 1, 0);
        end else begin
          e = sb.pop_front();
          seen = 1'b1;
          check({tag, ".latency"}, c + 1, 6);
          check({tag, ".hit"}, hit, e.hit);
          check({tag, ".cause"}, hit_cause, e.cause);
          check({tag, ".pipe"}, hit_pipe, e.pipe);
        end
      end
    end
    if (rst_at == 0 && !seen) check({tag, ".done_timeout"}, 0, 1);
    if (rst_at != 0) check_result_zero({tag, ".after_reset"});
  endtask

  initial begin
    tick();
    tick();
    Reset_n = 1'b1;
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.overrun", overrun, 0);
    check_result_zero("reset");

    clear_pipes();
    set_pipe(0, 320, 240);
    run_frame("clean", 240, 0, 0, 0, 0, 0, 0);

    clear_pipes();
    set_pipe(0, 320, 30);
    run_frame("low_bird_no_wrap", 11, 0, 0, 0, 0, 0, 0);

    clear_pipes();
    set_pipe(0, 264, 100);
    run_frame("x_reach_edge_miss", 240, 0, 0, 0, 0, 0, 0);

    clear_pipes();
    set_pipe(0, 320, 240);
    run_frame("gap_lip_hit", 270, 1, 1, 0, 0, 0, 0);
    run_frame("sticky_clean", 240, 1, 1, 0, 0, 0, 0);

    clear_hit = 1'b1;
    tick();
    clear_hit = 1'b0;
    check_result_zero("clear1");

    clear_pipes();
    set_pipe(0, 200, 100);
    set_pipe(1, 265, 100);
    set_pipe(2, 200, 100);
    set_pipe(3, 375, 100);
    run_frame("first_index_kept", 240, 1, 1, 1, 0, 0, 0);

    clear_pipes();
    set_pipe(0, 320, 240);
    run_frame("floor_over_pipe", 470, 1, 2, 0, 0, 0, 0);
    run_frame("ceil_over_pipe", 10, 1, 3, 0, 0, 0, 0);

    clear_hit = 1'b1;
    tick();
    clear_hit = 1'b0;
    check_result_zero("clear2");

    run_frame("overrun_mid_scan", 240, 0, 0, 0, 3, 0, 0);
    run_frame("clear_vs_done", 270, 1, 1, 0, 0, 5, 0);
    run_frame("reset_mid_scan", 240, 0, 0, 0, 0, 0, 2);

    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/collision_scan.md
# collision_scan

Multi-pipe collision detector for the Flappy Bird game core, replacing the single-pipe, single-cycle checker. Once per video frame it captures the bird position and up to NUM_PIPES pipe positions, then scans the pipes one per clock. It reports a registered collision verdict with cause and pipe index to the game state machine. Arithmetic is signed and widened, so a bird near screen edges never wraps.

## Interface
- NUM_PIPES, 4: pipe channels scanned per frame (1..16)
- COORD_W, 10: coordinate width
- BIRD_X, 320: fixed bird x centre
- X_REACH, 55: horizontal overlap half-range (pipe half-width + bird half-width)
- BIRD_HALF_H, 12: bird half-height
- GAP_HALF, 40: pipe gap half-height
- FLOOR_Y, 470 / CEIL_Y, 10: bird_y at or beyond these is a boundary hit
- STICKY, 1: 1 = hit latches until clear_hit; 0 = hit reflects last completed scan
- Clk  in  1  system clock; all logic on rising edge
- Reset_n  in  1  synchronous, active-low reset
- frame_start  in  1  one-cycle pulse (vsync edge) requesting a scan
- clear_hit  in  1  clears latched result (game restart)
- bird_y  in  COORD_W  bird y centre
- pipe_x  in  NUM_PIPES*COORD_W  pipe x centres, pipe i at [i*COORD_W +: COORD_W]
- pipe_y  in  NUM_PIPES*COORD_W  gap y centres, same packing
- pipe_valid  in  NUM_PIPES  pipe i on screen
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse, result updated this cycle
- hit  out  1  collision verdict
- hit_cause  out  2  0 none, 1 pipe, 2 floor, 3 ceiling
- hit_pipe  out  clog2(NUM_PIPES) (min 1)  index of hitting pipe; 0 unless cause = pipe
- overrun  out  1  one-cycle pulse: frame_start arrived while busy

## Operation
- FSM states IDLE, BOUND, SCAN, DONE.
- IDLE: on frame_start, capture all inputs into shadow registers, then go to BOUND. Inputs are not sampled again during the scan.
- BOUND: evaluate captured bird_y. Floor if bird_y >= FLOOR_Y. Ceiling if bird_y <= CEIL_Y. Clear the scan result, set idx = 0, go to SCAN.
- SCAN: one pipe per cycle, idx 0..NUM_PIPES-1. Pipe i hits when pipe_valid[i] is set and |pipe_x - BIRD_X| <= X_REACH, and either bird_y + BIRD_HALF_H >= pipe_y + GAP_HALF or bird_y - BIRD_HALF_H <= pipe_y - GAP_HALF.
- All comparisons use signed COORD_W+2-bit operands; no wrap-around.
- The first hitting index is kept; later hits do not overwrite it. After the last idx, go to DONE.
- DONE: assert done and update outputs, then return to IDLE.
- Cause priority: floor > ceiling > pipe (lowest index). hit = (cause != 0).
- STICKY=1: an update only sets the result; a no-hit scan leaves a latched hit untouched.
- STICKY=0: every update overwrites the result.
- clear_hit zeroes hit, hit_cause and hit_pipe. If it coincides with a DONE update, the update wins.
- frame_start outside IDLE is ignored and pulses overrun the next cycle.
- A frame_start coincident with DONE is also an overrun.

## Timing
- Reset (Reset_n = 0 at an edge) forces IDLE. busy, done, hit, hit_cause, hit_pipe and overrun all go to 0.
- Reset mid-scan aborts the scan with no done pulse.
- frame_start high in cycle T gives busy high in cycles T+1..T+NUM_PIPES+2.
- done and the updated result appear in cycle T+NUM_PIPES+2.
- Earliest accepted next frame_start is cycle T+NUM_PIPES+3.
- Outputs are registered; no combinational path from inputs to outputs.

## Structure
- collision_pkg holds the state enum, the hit_cause_t enum (HC_NONE, HC_PIPE, HC_FLOOR, HC_CEIL) and the signed-widening width constant.
- One sub-module, pipe_overlap: a purely combinational single-pipe test taking captured bird_y, pipe_x, pipe_y, valid and the geometry parameters, returning hit. It is instantiated once, fed by an idx mux.

## Test plan
- Defaults, bird_y=240, pipe0 (x=320, y=240, valid), others invalid, frame_start → done at T+6, hit=0, cause=0.
- bird_y=270, pipe0 (320, 240) → hit=1, cause=1, pipe=0 (282 >= 280 boundary).
- bird_y=11, pipe0 (320, 30), no pipe hit possible → hit=0. This covers the negative bird_y - 12 = -1 case with no wrap.
- bird_y=470 with pipe0 also hitting → cause=2. bird_y=10 → cause=3.
- Pipes 1 and 3 both hitting (x=265 and x=375, y=100, bird_y=240), pipes 0 and 2 at x=200 → hit_pipe=1. Pipe at x=264 → no hit.
- STICKY=1: hit, then clean frame → hit stays 1. clear_hit → 0. frame_start at T+3 → overrun pulse, done still at T+6. Reset_n low at T+2 → no done, outputs 0.
